// File: rtl/debounced_button_pio.sv
// Avalon-MM button/switch PIO: per-bit synchroniser, per-channel debounce
// counter with run-time limit, rising/falling edge capture and masked irq.
module debounced_button_pio #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned DEBOUNCE_RESET = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [CNT_W-1:0] debounce;
  logic [CNT_W-1:0] lim_m1;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic [31:0]      rd_mux;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign wr     = chipselect & ~write_n;
  // A limit of 0 behaves as 1, so the terminal count never underflows.
  assign lim_m1 = (debounce == '0) ? '0 : debounce - CNT_W'(1);
  assign rise   = stable & ~stable_d & rise_en;
  assign fall   = ~stable & stable_d & fall_en;
  assign clr    = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
  assign irq    = |(edge_capture & irq_mask);

  // Synchroniser chain for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Per-channel debounce: a mismatch must persist for the limit before stable follows.
  // Using >= lets a lowered limit take effect on the next mismatching clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable   <= '0;
      stable_d <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= lim_m1) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Control registers and edge capture; a new edge wins over a simultaneous W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en      <= '0;
      fall_en      <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      debounce     <= CNT_W'(DEBOUNCE_RESET);
    end else begin
      if (wr) begin
        case (address)
          3'd1:    rise_en  <= writedata[WIDTH-1:0];
          3'd2:    irq_mask <= writedata[WIDTH-1:0];
          3'd4:    fall_en  <= writedata[WIDTH-1:0];
          3'd6:    debounce <= writedata[CNT_W-1:0];
          default: ;
        endcase
      end
      edge_capture <= (edge_capture & ~clr) | rise | fall;
    end
  end

  // Read mux; unused upper bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[WIDTH-1:0] = stable;
      3'd1:    rd_mux[WIDTH-1:0] = rise_en;
      3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      3'd4:    rd_mux[WIDTH-1:0] = fall_en;
      3'd5:    rd_mux[WIDTH-1:0] = sync;
      3'd6:    rd_mux[CNT_W-1:0] = debounce;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, updated every clock independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_debounced_button_pio.sv
// Bench for debounced_button_pio: register table plus multi-cycle sequences.
module tb_debounced_button_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  in_port = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  debounced_button_pio dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string nm);
    sb_t e;
    @(negedge clk);
    address = a;
    sbq.push_back('{exp: exp, name: nm});
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk(e.name, readdata, e.exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int rel;
    int delta;

    vecs.push_back('{3'd0, 1'b0, 32'h0, 32'h0, "rst_data"});
    vecs.push_back('{3'd1, 1'b0, 32'h0, 32'h0, "rst_rise_en"});
    vecs.push_back('{3'd2, 1'b0, 32'h0, 32'h0, "rst_irq_mask"});
    vecs.push_back('{3'd3, 1'b0, 32'h0, 32'h0, "rst_edge_cap"});
    vecs.push_back('{3'd4, 1'b0, 32'h0, 32'h0, "rst_fall_en"});
    vecs.push_back('{3'd5, 1'b0, 32'h0, 32'h0, "rst_raw"});
    vecs.push_back('{3'd6, 1'b0, 32'h0, 32'd50000, "rst_debounce"});
    vecs.push_back('{3'd7, 1'b0, 32'h0, 32'h0, "rst_addr7"});
    vecs.push_back('{3'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_000F, "rise_en_mask"});
    vecs.push_back('{3'd2, 1'b1, 32'hFFFF_FFFF, 32'h0000_000F, "irq_mask_mask"});
    vecs.push_back('{3'd4, 1'b1, 32'hFFFF_FFFF, 32'h0000_000F, "fall_en_mask"});
    vecs.push_back('{3'd6, 1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, "debounce_mask"});
    vecs.push_back('{3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0, "data_ro"});
    vecs.push_back('{3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0, "raw_ro"});
    vecs.push_back('{3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0, "addr7_ro"});
    vecs.push_back('{3'd3, 1'b1, 32'hFFFF_FFFF, 32'h0, "edge_cap_w1c_empty"});
    vecs.push_back('{3'd4, 1'b1, 32'h0, 32'h0, "fall_en_clear"});
    vecs.push_back('{3'd2, 1'b1, 32'h1, 32'h1, "irq_mask_set1"});
    vecs.push_back('{3'd1, 1'b1, 32'h1, 32'h1, "rise_en_set1"});
    vecs.push_back('{3'd6, 1'b1, 32'h4, 32'h4, "debounce_set4"});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].wdata);
      rd_chk(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // Pin-to-capture latency: 2 sync + 4 debounce + 1 edge = edge 7
    @(negedge clk);
    in_port = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t1_irq_cycle%0d", k), {31'd0, irq}, (k >= 7) ? 32'h1 : 32'h0);
    end
    rd_chk(3'd0, 32'h1, "t1_data");
    rd_chk(3'd3, 32'h1, "t1_edge_cap");

    // Bounce: 7 high, 1 low, then steady high with limit 8
    wr_reg(3'd3, 32'hF);
    wr_reg(3'd6, 32'd8);
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      address = 3'd0;
      in_port[1] = (n == 8) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      chk($sformatf("t2_data1_cycle%0d", n), {31'd0, readdata[1]}, (n >= 19) ? 32'h1 : 32'h0);
    end

    // Falling-only capture on bit1
    wr_reg(3'd4, 32'h2);
    wr_reg(3'd1, 32'h0);
    wr_reg(3'd3, 32'hF);
    @(negedge clk);
    in_port[1] = 1'b0;
    wait_cyc(20);
    rd_chk(3'd3, 32'h2, "t3_fall_captured");
    rd_chk(3'd0, 32'h1, "t3_data");
    wr_reg(3'd3, 32'hF);
    @(negedge clk);
    in_port[1] = 1'b1;
    wait_cyc(20);
    rd_chk(3'd3, 32'h0, "t3_rise_ignored");
    rd_chk(3'd0, 32'h3, "t3_data_high");

    // W1C colliding with a new rising edge on bit2
    wr_reg(3'd4, 32'h3);
    wr_reg(3'd1, 32'h4);
    @(negedge clk);
    in_port = 4'b0000;
    wait_cyc(20);
    rd_chk(3'd3, 32'h3, "t4_pre_cap");
    @(negedge clk);
    in_port[2] = 1'b1;
    repeat (10) @(posedge clk);
    wr_reg(3'd3, 32'hF);
    rd_chk(3'd3, 32'h4, "t4_set_wins");

    // irq masking
    wr_reg(3'd3, 32'hF);
    wr_reg(3'd1, 32'h3);
    @(negedge clk);
    in_port = 4'b0111;
    wait_cyc(20);
    rd_chk(3'd3, 32'h3, "t5_cap3");
    wr_reg(3'd2, 32'h0);
    chk("t5_irq_masked", {31'd0, irq}, 32'h0);
    wr_reg(3'd2, 32'h2);
    chk("t5_irq_unmasked", {31'd0, irq}, 32'h1);
    wr_reg(3'd3, 32'h2);
    chk("t5_irq_after_w1c", {31'd0, irq}, 32'h0);
    rd_chk(3'd3, 32'h1, "t5_cap_after_w1c");

    // Reset mid-debounce with inputs held high
    wr_reg(3'd3, 32'hF);
    wr_reg(3'd2, 32'h0);
    @(negedge clk);
    in_port[3] = 1'b1;
    wait_cyc(5);
    @(negedge clk);
    reset_n = 1'b0;
    wait_cyc(3);
    chk("t6_reset_readdata", readdata, 32'h0);
    chk("t6_reset_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    rd_chk(3'd6, 32'd50000, "t6_debounce_reset");
    rd_chk(3'd3, 32'h0, "t6_edge_cap_reset");
    rd_chk(3'd1, 32'h0, "t6_rise_en_reset");
    rd_chk(3'd0, 32'h0, "t6_data_reset");
    wr_reg(3'd1, 32'hF);
    wr_reg(3'd2, 32'hF);
    while (!irq && (cyc - rel) < 50020) begin
      @(posedge clk); #1;
    end
    delta = cyc - rel;
    chk("t6_irq_seen", {31'd0, irq}, 32'h1);
    chk("t6_latency_in_window", {31'd0, (delta >= 50001 && delta <= 50005)}, 32'h1);
    if (!(delta >= 50001 && delta <= 50005))
      $display("t6 latency was %0d cycles after release", delta);
    rd_chk(3'd3, 32'hF, "t6_edge_cap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
